regfile_port_ctrl: RTL and testbench

- Initiator side of the single-port register file: owns the shared addr/en/wr_data port and serialises operand reads and write-backs onto it.
- Accepts an operand-fetch request (one or two source registers) and returns captured values over a valid/ready response.
- Accepts write-backs over a separate valid/ready channel.
- Sits between decode/execute and the register file instance.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_port_ctrl.sv | 119 +++++++++++
 tb/tb_regfile_port_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file port controller,
// the register file itself and its bench model.
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_A,
    RD_B,
    RESP
  } state_e;

  localparam int CONST_BASE_DEF = 29;

  // Contents of the hard-wired registers at CONST_BASE, CONST_BASE+1, CONST_BASE+2
  localparam logic [15:0] CONST_ZERO = 16'h0000;
  localparam logic [15:0] CONST_ONE  = 16'h0001;
  localparam logic [15:0] CONST_ONES = 16'hFFFF;

endpackage

// File: rtl/regfile_port_ctrl.sv
// Initiator of the single-port register file: serialises operand fetches and write-backs.
// Optional write-back forwarding into held operands: define REGFILE_PORT_CTRL_FWD_EN.
module regfile_port_ctrl
  import regfile_pkg::*;
#(
  parameter int N          = 16,
  parameter int M          = 5,
  parameter int CONST_BASE = CONST_BASE_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [M-1:0] req_ra,
  input  logic [M-1:0] req_rb,
  input  logic         req_use_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_a,
  output logic [N-1:0] rsp_b,
  input  logic         wb_valid,
  output logic         wb_ready,
  input  logic [M-1:0] wb_addr,
  input  logic [N-1:0] wb_data,
  output logic [M-1:0] rf_addr,
  output logic         rf_en,
  output logic [N-1:0] rf_wr_data,
  input  logic [N-1:0] rf_rd_data
);

  localparam logic [M-1:0] ConstAddr = M'(CONST_BASE);

  state_e       state_q, state_d;
  logic [M-1:0] ra_q, ra_d;
  logic [M-1:0] rb_q, rb_d;
  logic         use_b_q, use_b_d;
  logic [N-1:0] rsp_a_q, rsp_a_d;
  logic [N-1:0] rsp_b_q, rsp_b_d;
  logic         run_q;
  logic         wb_fire;

  // The port is only free for a write-back while no operand read is in flight
  assign wb_ready   = run_q && ((state_q == IDLE) || (state_q == RESP));
  assign req_ready  = run_q && (state_q == IDLE) && !wb_valid;
  assign wb_fire    = wb_valid && wb_ready;
  assign rf_en      = wb_fire && (wb_addr < ConstAddr);
  assign rf_wr_data = wb_data;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_a      = rsp_a_q;
  assign rsp_b      = rsp_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      use_b_q <= 1'b0;
      rsp_a_q <= '0;
      rsp_b_q <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      use_b_q <= use_b_d;
      rsp_a_q <= rsp_a_d;
      rsp_b_q <= rsp_b_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    use_b_d = use_b_q;
    rsp_a_d = rsp_a_q;
    rsp_b_d = rsp_b_q;
    rf_addr = wb_fire ? wb_addr : ra_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          ra_d    = req_ra;
          rb_d    = req_rb;
          use_b_d = req_use_b;
          state_d = RD_A;
        end
      end
      RD_A: begin
        rf_addr = ra_q;
        rsp_a_d = rf_rd_data;
        if (use_b_q) begin
          state_d = RD_B;
        end else begin
          rsp_b_d = '0;
          state_d = RESP;
        end
      end
      RD_B: begin
        rf_addr = rb_q;
        rsp_b_d = rf_rd_data;
        state_d = RESP;
      end
      RESP: begin
`ifdef REGFILE_PORT_CTRL_FWD_EN
        // rf_en already excludes constant addresses, so it gates forwarding too
        if (rf_en) begin
          if (wb_addr == ra_q) rsp_a_d = wb_data;
          if (use_b_q && (wb_addr == rb_q)) rsp_b_d = wb_data;
        end
`endif
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Bench for regfile_port_ctrl: register-file responder, transaction-level model
// checked every cycle, and directed sequences with hand-computed expectations.
module tb_regfile_port_ctrl;
  import regfile_pkg::*;

  localparam logic [4:0] CB = 5'(CONST_BASE_DEF);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_ra = '0;
  logic [4:0]  req_rb = '0;
  logic        req_use_b = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_a;
  logic [15:0] rsp_b;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [4:0]  wb_addr = '0;
  logic [15:0] wb_data = '0;
  logic [4:0]  rf_addr;
  logic        rf_en;
  logic [15:0] rf_wr_data;
  logic [15:0] rf_rd_data;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  regfile_port_ctrl #(.N(16), .M(5), .CONST_BASE(CONST_BASE_DEF)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ra(req_ra), .req_rb(req_rb), .req_use_b(req_use_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_a(rsp_a), .rsp_b(rsp_b),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_addr(rf_addr), .rf_en(rf_en), .rf_wr_data(rf_wr_data), .rf_rd_data(rf_rd_data)
  );

  // Register file responder: combinational read, constants above CB never change
  logic [15:0] rfMem [0:31];
  assign rf_rd_data = (rf_addr == 5'd29) ? CONST_ZERO :
                      (rf_addr == 5'd30) ? CONST_ONE  :
                      (rf_addr == 5'd31) ? CONST_ONES : rfMem[rf_addr];

  always @(posedge clk) begin
    if (rf_en && rf_addr < CB) rfMem[rf_addr] <= rf_wr_data;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: register contents, one outstanding fetch and its age in cycles
  logic [15:0] refM [0:31];
  logic        runM = 1'b0;
  logic        pendM = 1'b0;
  logic        useBM = 1'b0;
  logic [4:0]  latRa = '0;
  logic [4:0]  latRb = '0;
  logic [15:0] expA = '0;
  logic [15:0] expB = '0;
  int          age = 0;

  always begin
    logic validM, wbRdyM, reqRdyM, wbFireM, reqFireM;
    logic [4:0] addrM;
    @(negedge clk);
    #2;
    if (!rst_n) begin
      runM = 1'b0;
      pendM = 1'b0;
      useBM = 1'b0;
      latRa = '0;
      latRb = '0;
      age = 0;
    end
    validM   = pendM && (age >= (useBM ? 3 : 2));
    wbRdyM   = runM && (!pendM || validM);
    reqRdyM  = runM && !pendM && !wb_valid;
    wbFireM  = wb_valid && wbRdyM;
    reqFireM = req_valid && reqRdyM;
    if (wbFireM) addrM = wb_addr;
    else if (pendM && age == 2 && useBM) addrM = latRb;
    else addrM = latRa;

    checkOutput("cyc_rsp_valid", 32'(rsp_valid), 32'(validM));
    checkOutput("cyc_req_ready", 32'(req_ready), 32'(reqRdyM));
    checkOutput("cyc_wb_ready", 32'(wb_ready), 32'(wbRdyM));
    checkOutput("cyc_rf_en", 32'(rf_en), 32'(wbFireM && wb_addr < CB));
    checkOutput("cyc_rf_addr", 32'(rf_addr), 32'(addrM));
    checkOutput("cyc_rf_wr_data", 32'(rf_wr_data), 32'(wb_data));
    if (validM) begin
      checkOutput("cyc_rsp_a", 32'(rsp_a), 32'(expA));
      checkOutput("cyc_rsp_b", 32'(rsp_b), 32'(expB));
    end

    if (rst_n) begin
      if (wbFireM && wb_addr < CB) begin
        refM[wb_addr] = wb_data;
`ifdef REGFILE_PORT_CTRL_FWD_EN
        if (validM && wb_addr == latRa) expA = wb_data;
        if (validM && useBM && wb_addr == latRb) expB = wb_data;
`endif
      end
      if (validM && rsp_ready) pendM = 1'b0;
      if (pendM) age++;
      if (reqFireM) begin
        pendM = 1'b1;
        age = 1;
        latRa = req_ra;
        latRb = req_rb;
        useBM = req_use_b;
        expA = refM[req_ra];
        expB = req_use_b ? refM[req_rb] : 16'h0000;
      end
      runM = 1'b1;
    end
  end

  task automatic applyStimulus(input logic wv, input logic [4:0] wa, input logic [15:0] wd,
                               input logic rv, input logic [4:0] ra, input logic [4:0] rb,
                               input logic ub);
    @(negedge clk);
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    req_valid = rv; req_ra = ra; req_rb = rb; req_use_b = ub;
  endtask

  task automatic startFetch(input logic [4:0] ra, input logic [4:0] rb, input logic ub);
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b1, ra, rb, ub);
    #3 checkOutput("accept_req_ready", 32'(req_ready), 32'd1);
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, ra, rb, ub);
  endtask

  task automatic waitResp(input int expLat, input logic [15:0] ea, input logic [15:0] eb);
    int lat = 0;
    for (int k = 1; k <= 8; k++) begin
      #3;
      if (rsp_valid) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    checkOutput("rsp_latency", 32'(lat), 32'(expLat));
    checkOutput("rsp_a_value", 32'(rsp_a), 32'(ea));
    checkOutput("rsp_b_value", 32'(rsp_b), 32'(eb));
  endtask

  task automatic finishResp(input int hold, input logic [15:0] ea, input logic [15:0] eb);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #3;
      checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("hold_rsp_a", 32'(rsp_a), 32'(ea));
      checkOutput("hold_rsp_b", 32'(rsp_b), 32'(eb));
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #3 checkOutput("after_hs_rsp_valid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rfMem[i] = 16'h0000;
      refM[i] = 16'h0000;
    end
    refM[29] = CONST_ZERO;
    refM[30] = CONST_ONE;
    refM[31] = CONST_ONES;

    repeat (2) @(negedge clk);
    #3 checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #3 checkOutput("pre_run_req_ready", 32'(req_ready), 32'd0);

    // Plain write-back, then single-operand fetch of the written register
    applyStimulus(1'b1, 5'd5, 16'hABCD, 1'b0, 5'd0, 5'd0, 1'b0);
    #3 checkOutput("wb5_rf_en", 32'(rf_en), 32'd1);
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 5'd0, 1'b0);
    #3 checkOutput("wb5_rf_en_drop", 32'(rf_en), 32'd0);
    startFetch(5'd5, 5'd0, 1'b0);
    waitResp(2, 16'hABCD, 16'h0000);
    finishResp(0, 16'hABCD, 16'h0000);

    // Two operands, consumer stalls four cycles
    startFetch(5'd5, 5'd31, 1'b1);
    waitResp(3, 16'hABCD, 16'hFFFF);
    finishResp(4, 16'hABCD, 16'hFFFF);

    // Write to a constant register is accepted but never reaches the file
    applyStimulus(1'b1, 5'd30, 16'h1234, 1'b0, 5'd0, 5'd0, 1'b0);
    #3 checkOutput("wb30_wb_ready", 32'(wb_ready), 32'd1);
    checkOutput("wb30_rf_en", 32'(rf_en), 32'd0);
    startFetch(5'd30, 5'd0, 1'b0);
    waitResp(2, 16'h0001, 16'h0000);
    finishResp(0, 16'h0001, 16'h0000);

    // Write-back wins over a request in IDLE
    applyStimulus(1'b1, 5'd7, 16'h1111, 1'b1, 5'd7, 5'd0, 1'b0);
    #3 checkOutput("prio_req_ready", 32'(req_ready), 32'd0);
    checkOutput("prio_wb_ready", 32'(wb_ready), 32'd1);
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b1, 5'd7, 5'd0, 1'b0);
    #3 checkOutput("prio_req_ready_next", 32'(req_ready), 32'd1);
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 5'd7, 5'd0, 1'b0);
    waitResp(2, 16'h1111, 16'h0000);
    finishResp(0, 16'h1111, 16'h0000);

    // Write-back to a held operand while the response stalls
    startFetch(5'd5, 5'd31, 1'b1);
    waitResp(3, 16'hABCD, 16'hFFFF);
    applyStimulus(1'b1, 5'd5, 16'h0042, 1'b0, 5'd0, 5'd0, 1'b0);
    #3 checkOutput("fwd_rf_en", 32'(rf_en), 32'd1);
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 5'd0, 1'b0);
`ifdef REGFILE_PORT_CTRL_FWD_EN
    #3 checkOutput("fwd_rsp_a", 32'(rsp_a), 32'h0042);
    finishResp(0, 16'h0042, 16'hFFFF);
`else
    #3 checkOutput("fwd_rsp_a", 32'(rsp_a), 32'hABCD);
    finishResp(0, 16'hABCD, 16'hFFFF);
`endif

    // Reset while the second operand is being read
    startFetch(5'd5, 5'd31, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #3 checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_rf_en", 32'(rf_en), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #3 checkOutput("rel_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    #3 checkOutput("run_req_ready", 32'(req_ready), 32'd1);

    // Response handshake and write-back complete in the same cycle
    startFetch(5'd5, 5'd7, 1'b1);
    waitResp(3, 16'h0042, 16'h1111);
    applyStimulus(1'b1, 5'd9, 16'h5A5A, 1'b0, 5'd0, 5'd0, 1'b0);
    rsp_ready = 1'b1;
    #3 checkOutput("dual_rf_en", 32'(rf_en), 32'd1);
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 5'd0, 1'b0);
    rsp_ready = 1'b0;
    #3 checkOutput("dual_rsp_valid", 32'(rsp_valid), 32'd0);
    startFetch(5'd9, 5'd0, 1'b0);
    waitResp(2, 16'h5A5A, 16'h0000);
    finishResp(0, 16'h5A5A, 16'h0000);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected end before 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
